// File: rtl/countdown_timer_if.sv
// Handshake and count signals of the countdown timer, grouped for port connection.
// The master side drives load/start/pause; the slave side (the timer) reports count and status.
interface countdown_timer_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 i_load;
  logic [CNT_WIDTH-1:0] i_load_val;
  logic                 i_start;
  logic                 i_pause;
  logic [CNT_WIDTH-1:0] o_count;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_zero;

  modport master (
    output i_load, i_load_val, i_start, i_pause,
    input  o_count, o_busy, o_done, o_zero
  );

  modport slave (
    input  i_load, i_load_val, i_start, i_pause,
    output o_count, o_busy, o_done, o_zero
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/pause/done handshake and a registered one-cycle done pulse.
// Define COUNTDOWN_AUTORELOAD_EN to reload the count from the reload register on the terminal edge.
module countdown_timer #(
  parameter int CNT_WIDTH = 8
) (
  input logic              i_clk,
  input logic              i_reset,
  countdown_timer_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t               r_state;
  state_t               w_stateNext;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] w_countNext;
  logic [CNT_WIDTH-1:0] r_reload;
  logic [CNT_WIDTH-1:0] w_reloadNext;
  logic                 r_done;
  logic                 w_doneNext;
  logic                 w_terminal;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_count  <= w_countNext;
      r_reload <= w_reloadNext;
      r_done   <= w_doneNext;
    end
  end

  assign w_terminal = (r_count == CNT_WIDTH'(1));

  // Priority is load, then start, then pause; load always aborts back to IDLE.
  always_comb begin
    w_stateNext  = r_state;
    w_countNext  = r_count;
    w_reloadNext = r_reload;
    w_doneNext   = 1'b0;
    if (bus.i_load) begin
      w_countNext  = bus.i_load_val;
      w_reloadNext = bus.i_load_val;
      w_stateNext  = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            if (r_count != '0) begin
              w_stateNext = RUN;
            end else begin
              w_doneNext = 1'b1;
            end
          end
        end
        RUN: begin
          if (!bus.i_pause) begin
            if (w_terminal) begin
              w_doneNext = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
              // A zero reload value cannot sustain a periodic tick, so fall back to stopping.
              if (r_reload != '0) begin
                w_countNext = r_reload;
              end else begin
                w_countNext = '0;
                w_stateNext = IDLE;
              end
`else
              w_countNext = '0;
              w_stateNext = IDLE;
`endif
            end else if (r_count == '0) begin
              w_stateNext = IDLE;
            end else begin
              w_countNext = r_count - CNT_WIDTH'(1);
            end
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.o_count = r_count;
    bus.o_busy  = (r_state == RUN);
    bus.o_done  = r_done;
    bus.o_zero  = (r_count == '0);
  end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter with a start/pause/done handshake. It is the counting-down counterpart of the free-running up-counter.
- Software or a sequencer does the following: loads a terminal count, pulses start, and receives a single-cycle done pulse when the count reaches zero.
- Used for timeouts, delay generation and periodic ticks.

Parameters:
- CNT_WIDTH, 8, width of count, load value and reload register.

Ports:
- i_clk  input  1  clock, rising-edge.
- i_reset  input  1  reset, asynchronous, active-high.
- i_load  input  1  load strobe; captures i_load_val.
- i_load_val  input  CNT_WIDTH  value to load.
- i_start  input  1  start strobe.
- i_pause  input  1  level; holds count while high in RUN.
- o_count  output  CNT_WIDTH  current count value.
- o_busy  output  1  high while in RUN.
- o_done  output  1  one-cycle pulse on reaching zero.
- o_zero  output  1  combinational, o_count == 0.

Behaviour:
- Clock and reset: i_clk is the clock. i_reset is asynchronous and active-high.
- Reset values (immediate, asynchronous):
  - o_count = 0, reload register = 0.
  - State = IDLE, so o_busy = 0.
  - o_done = 0.
- States: IDLE, RUN. o_busy = (state == RUN), registered via state.
- Input priority per edge: i_load > i_start > i_pause.
- Load:
  - When i_load = 1 at an edge, count and reload register both take i_load_val.
  - State goes to IDLE, aborting any run. o_done = 0 that cycle.
  - Load is accepted in any state.
- Start:
  - Applies in IDLE, with i_load = 0 and count != 0.
  - At edge e the state goes to RUN and count is unchanged.
  - Decrementing begins at edge e+1.
- Start with a zero count:
  - Applies in IDLE with count == 0 and i_load = 0.
  - o_done pulses for one cycle after the edge. State stays IDLE.
- Start while in RUN: ignored, with no restart.
- RUN, i_pause = 0: count decrements by 1 per edge.
- RUN, i_pause = 1: count holds and state stays RUN. A pause asserted on the start edge has no effect on that edge.
- Terminal edge:
  - This is the edge where count goes from 1 to 0.
  - At that edge, o_done = 1 for exactly one cycle and the state returns to IDLE (see the optional feature for the alternative).
- Latency: for load value N (nonzero) and start at edge e, with no pause:
  - o_count reaches 0 at edge e+N.
  - o_done is high from edge e+N to edge e+N+1.
  - o_busy is high for edges e+1 through e+N.
- No underflow: the count never decrements below 0. In IDLE the count holds.
- Arithmetic: unsigned, CNT_WIDTH bits. Maximum run is 2^CNT_WIDTH - 1 cycles.
- Reset mid-RUN: count is 0 and IDLE immediately. No o_done is produced.
- Simultaneous load and the terminal edge: load wins. Count = i_load_val, IDLE, o_done = 0.
- o_done is registered. o_done is 0 on every edge other than those described above.

Optional Feature:
- Macro name: COUNTDOWN_AUTORELOAD_EN.
- Defined, terminal edge in RUN:
  - count takes the reload register value, the state stays RUN, and o_done pulses.
  - This gives a periodic tick every N cycles (excluding paused cycles).
  - o_zero is not asserted at the terminal edge.
- Defined, reload register = 0: the block behaves as if the macro were undefined (returns to IDLE).
- Defined, stopping: auto-reload runs stop only on i_load or reset.
- Undefined: the terminal edge goes to IDLE with count = 0. The reload register is still written on load but is unused.

Test Plan:
- Load 5, start, no pause:
  - o_busy rises the edge after start.
  - o_count goes 5,4,3,2,1,0 on successive edges.
  - o_done is high exactly one cycle, aligned with o_count = 0.
  - o_busy falls with the terminal edge. Total run is 5 cycles.
- Load 10, start, pause for 3 cycles mid-count at value 6:
  - o_count holds at 6 for 3 cycles.
  - o_done arrives 13 cycles after start.
- Reset asserted mid-run at count 7: o_count = 0 and o_busy = 0 immediately (asynchronous), with no o_done.
- Start with count 0 after reset:
  - o_done pulses one cycle and o_busy stays 0.
  - Start on the same edge as load 3: load wins, o_count = 3, IDLE, no run.
- Load 255 (CNT_WIDTH = 8), start:
  - Exactly 255 decrements, then o_done.
  - o_count stays 0 for a further 20 cycles, with no wrap to 255.
- With COUNTDOWN_AUTORELOAD_EN, load 4 and start:
  - o_done pulses every 4 cycles for at least 5 periods.
  - o_count cycles 3,2,1,4,3,...
  - Load 0 stops it, giving IDLE with count 0.
